// File: rtl/conv2d_row_scheduler_pkg.sv
// Shared types and limits for the Conv2d row scheduler.
// The optional abort feature is enabled by defining CONV2D_ROW_SCHED_ABORT_EN.
package conv2d_pkg;
  localparam int MAX_IMG_SIZE = 128;
  localparam int MIN_IMG_SIZE = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_FINISH
  } state_e;

  function automatic logic size_ok(input logic [7:0] size);
    return (size >= 8'(MIN_IMG_SIZE)) && (size <= 8'(MAX_IMG_SIZE));
  endfunction
endpackage

// File: rtl/conv2d_row_scheduler_if.sv
// Controller / line-buffer signal bundle for conv2d_row_scheduler.
// master = scheduler side; the abort pair exists only with CONV2D_ROW_SCHED_ABORT_EN.
interface conv2d_row_scheduler_if #(parameter int CH_WIDTH = 10);
  logic                start;
  logic [7:0]          IMAGE_SIZE;
  logic [CH_WIDTH-1:0] NUM_CHANNELS;
  logic                Done_1row;
  logic                Input_line_buffer_IDLE;
  logic                Stream_first_row;
  logic                Stream_mid_row;
  logic                Stream_last_row;
  logic                last_channel;
  logic [7:0]          row_idx;
  logic [CH_WIDTH-1:0] ch_idx;
  logic                busy;
  logic                done;
  logic                cfg_err;
`ifdef CONV2D_ROW_SCHED_ABORT_EN
  logic                abort;
  logic                aborted;

  modport master (
    input  start, IMAGE_SIZE, NUM_CHANNELS, Done_1row, Input_line_buffer_IDLE, abort,
    output Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
           row_idx, ch_idx, busy, done, cfg_err, aborted
  );
  modport slave (
    output start, IMAGE_SIZE, NUM_CHANNELS, Done_1row, Input_line_buffer_IDLE, abort,
    input  Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
           row_idx, ch_idx, busy, done, cfg_err, aborted
  );
`else
  modport master (
    input  start, IMAGE_SIZE, NUM_CHANNELS, Done_1row, Input_line_buffer_IDLE,
    output Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
           row_idx, ch_idx, busy, done, cfg_err
  );
  modport slave (
    output start, IMAGE_SIZE, NUM_CHANNELS, Done_1row, Input_line_buffer_IDLE,
    input  Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
           row_idx, ch_idx, busy, done, cfg_err
  );
`endif
endinterface

// File: rtl/conv2d_row_scheduler.sv
// Walks the input line buffer over a feature map: channel outer, row inner, one row command
// per row. Optional abort via CONV2D_ROW_SCHED_ABORT_EN.
module conv2d_row_scheduler
  import conv2d_pkg::*;
#(
  parameter int CH_WIDTH = 10
) (
  input logic                   clk,
  input logic                   Reset,
  conv2d_row_scheduler_if.master bus
);
  localparam logic [CH_WIDTH-1:0] CH_ONE = {{(CH_WIDTH-1){1'b0}}, 1'b1};

  state_e              state, state_n;
  logic [7:0]          row_q, row_n, size_q, size_n;
  logic [CH_WIDTH-1:0] ch_q, ch_n, nch_q, nch_n;
  logic                first_q, first_n, mid_q, mid_n, last_q, last_n;
  logic                lastch_q, lastch_n, busy_q, busy_n;
  logic                done_q, done_n, err_q, err_n;
  logic                aborted_n;
  logic                row_last, ch_last;

  // Bounds come from the latched config, so counters can never run past it.
  assign row_last = (row_q == size_q - 8'd1);
  assign ch_last  = (ch_q == nch_q - CH_ONE);

  always_comb begin
    state_n   = state;
    row_n     = row_q;
    ch_n      = ch_q;
    size_n    = size_q;
    nch_n     = nch_q;
    first_n   = 1'b0;
    mid_n     = 1'b0;
    last_n    = 1'b0;
    err_n     = 1'b0;
    aborted_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (size_ok(bus.IMAGE_SIZE) && (bus.NUM_CHANNELS != '0)) begin
            state_n = S_WAIT_IDLE;
            size_n  = bus.IMAGE_SIZE;
            nch_n   = bus.NUM_CHANNELS;
            row_n   = '0;
            ch_n    = '0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (bus.Input_line_buffer_IDLE) begin
          // Size is at least 3, so first and last can never coincide.
          state_n = S_ISSUE;
          first_n = (row_q == 8'd0);
          last_n  = row_last;
          mid_n   = (row_q != 8'd0) && !row_last;
        end
      end
      S_ISSUE: state_n = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.Done_1row) begin
          if (row_last && ch_last) begin
            state_n = S_FINISH;
          end else if (row_last) begin
            row_n   = '0;
            ch_n    = ch_q + CH_ONE;
            state_n = S_WAIT_IDLE;
          end else begin
            row_n   = row_q + 8'd1;
            state_n = S_WAIT_IDLE;
          end
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
`ifdef CONV2D_ROW_SCHED_ABORT_EN
    if (bus.abort && (state != S_IDLE)) begin
      state_n   = S_IDLE;
      row_n     = row_q;
      ch_n      = ch_q;
      first_n   = 1'b0;
      mid_n     = 1'b0;
      last_n    = 1'b0;
      aborted_n = 1'b1;
    end
`endif
    busy_n   = (state_n != S_IDLE);
    done_n   = (state_n == S_FINISH);
    lastch_n = busy_n && (ch_n == nch_n - CH_ONE);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      row_q    <= '0;
      ch_q     <= '0;
      size_q   <= '0;
      nch_q    <= '0;
      first_q  <= 1'b0;
      mid_q    <= 1'b0;
      last_q   <= 1'b0;
      lastch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      row_q    <= row_n;
      ch_q     <= ch_n;
      size_q   <= size_n;
      nch_q    <= nch_n;
      first_q  <= first_n;
      mid_q    <= mid_n;
      last_q   <= last_n;
      lastch_q <= lastch_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

`ifdef CONV2D_ROW_SCHED_ABORT_EN
  logic aborted_q;
  always_ff @(posedge clk) begin
    if (Reset) aborted_q <= 1'b0;
    else       aborted_q <= aborted_n;
  end
  assign bus.aborted = aborted_q;
`endif

  assign bus.Stream_first_row = first_q;
  assign bus.Stream_mid_row   = mid_q;
  assign bus.Stream_last_row  = last_q;
  assign bus.last_channel     = lastch_q;
  assign bus.row_idx          = row_q;
  assign bus.ch_idx           = ch_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.cfg_err          = err_q;
endmodule

// File: tb/tb_conv2d_row_scheduler.sv
// Directed bench for conv2d_row_scheduler: full maps, bad configs, buffer stall, reset, abort.
module tb_conv2d_row_scheduler;
  import conv2d_pkg::*;

  localparam int CHW = 10;
  localparam logic [2:0] K_FIRST = 3'b100;
  localparam logic [2:0] K_MID   = 3'b010;
  localparam logic [2:0] K_LAST  = 3'b001;

  logic clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   stream_cnt = 0;
  int   done_cnt = 0;

  conv2d_row_scheduler_if #(.CH_WIDTH(CHW)) bus ();

  conv2d_row_scheduler #(.CH_WIDTH(CHW)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!Reset) begin
      stream_cnt <= stream_cnt + int'(bus.Stream_first_row) + int'(bus.Stream_mid_row)
                    + int'(bus.Stream_last_row);
      done_cnt   <= done_cnt + int'(bus.done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] kind_now();
    return {bus.Stream_first_row, bus.Stream_mid_row, bus.Stream_last_row};
  endfunction

  task automatic wait_stream(input int max, output logic [2:0] kind, output int cyc);
    kind = 3'b000;
    cyc  = 0;
    while (cyc < max && kind == 3'b000) begin
      tick();
      cyc++;
      kind = kind_now();
    end
  endtask

  task automatic start_map(input logic [7:0] size, input logic [CHW-1:0] nch);
    bus.IMAGE_SIZE   = size;
    bus.NUM_CHANNELS = nch;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  // Waits for a row command and checks its kind, latency and indices.
  task automatic await_row(input string tag, input logic [2:0] exp_kind, input int exp_lat,
                           input int r, input int c, input logic lc, input int from_cyc);
    logic [2:0] kind;
    int cyc;
    wait_stream(10, kind, cyc);
    chk({tag, "_kind"}, 32'(kind), 32'(exp_kind));
    chk({tag, "_lat"},  32'(cyc + from_cyc), 32'(exp_lat));
    chk({tag, "_row"},  32'(bus.row_idx), 32'(r));
    chk({tag, "_ch"},   32'(bus.ch_idx), 32'(c));
    chk({tag, "_lastch"}, 32'(bus.last_channel), 32'(lc));
  endtask

  // Streams are one-cycle pulses; Done_1row follows five cycles after the command.
  task automatic finish_row(input string tag, input logic final_row);
    tick();
    chk({tag, "_pulse1"}, 32'(kind_now()), 32'd0);
    repeat (4) tick();
    bus.Done_1row = 1'b1;
    tick();
    bus.Done_1row = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'(final_row));
  endtask

  task automatic run_map(input string tag, input int size, input int nch);
    int s0, d0;
    logic [2:0] k;
    s0 = stream_cnt;
    d0 = done_cnt;
    start_map(8'(size), CHW'(nch));
    for (int c = 0; c < nch; c++) begin
      for (int r = 0; r < size; r++) begin
        k = (r == 0) ? K_FIRST : (r == size - 1) ? K_LAST : K_MID;
        // Latency counts from the cycle start or Done_1row was sampled.
        await_row($sformatf("%s_c%0dr%0d", tag, c, r), k, 2, r, c, (c == nch - 1), 1);
        finish_row($sformatf("%s_c%0dr%0d", tag, c, r), (c == nch - 1) && (r == size - 1));
      end
    end
    tick();
    chk({tag, "_done_off"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    chk({tag, "_lastch_idle"}, 32'(bus.last_channel), 32'd0);
    chk({tag, "_streams"}, 32'(stream_cnt - s0), 32'(size * nch));
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int s0, d0;
    bus.start = 1'b0;
    bus.IMAGE_SIZE = 8'd0;
    bus.NUM_CHANNELS = '0;
    bus.Done_1row = 1'b0;
    bus.Input_line_buffer_IDLE = 1'b1;
`ifdef CONV2D_ROW_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    Reset = 1'b1;
    repeat (2) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_streams", 32'(kind_now()), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_lastch", 32'(bus.last_channel), 32'd0);
    chk("rst_row", 32'(bus.row_idx), 32'd0);
    chk("rst_ch", 32'(bus.ch_idx), 32'd0);
    Reset = 1'b0;
    tick();

    // 1: 4x4, one channel
    run_map("t1", 4, 1);
    // 2: 3x3, three channels
    run_map("t2", 3, 3);

    // 3: rejected configurations
    start_map(8'd2, 10'd1);
    chk("t3_sz2_err", 32'(bus.cfg_err), 32'd1);
    chk("t3_sz2_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t3_sz2_err_off", 32'(bus.cfg_err), 32'd0);
    start_map(8'd4, 10'd0);
    chk("t3_nch0_err", 32'(bus.cfg_err), 32'd1);
    chk("t3_nch0_busy", 32'(bus.busy), 32'd0);
    start_map(8'd129, 10'd1);
    chk("t3_sz129_err", 32'(bus.cfg_err), 32'd1);
    chk("t3_sz129_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t3_err_off", 32'(bus.cfg_err), 32'd0);

    // 4: buffer stalls after the first row, stray Done_1row while waiting
    start_map(8'd3, 10'd1);
    await_row("t4_r0", K_FIRST, 2, 0, 0, 1'b1, 1);
    repeat (5) tick();
    bus.Done_1row = 1'b1;
    bus.Input_line_buffer_IDLE = 1'b0;
    tick();
    bus.Done_1row = 1'b0;
    s0 = stream_cnt;
    for (int i = 0; i < 20; i++) begin
      bus.Done_1row = (i == 5);
      tick();
    end
    bus.Done_1row = 1'b0;
    chk("t4_stall_streams", 32'(stream_cnt - s0), 32'd0);
    chk("t4_stall_row", 32'(bus.row_idx), 32'd1);
    chk("t4_stall_busy", 32'(bus.busy), 32'd1);
    bus.Input_line_buffer_IDLE = 1'b1;
    await_row("t4_r1", K_MID, 1, 1, 0, 1'b1, 0);
    finish_row("t4_r1", 1'b0);
    await_row("t4_r2", K_LAST, 2, 2, 0, 1'b1, 1);
    finish_row("t4_r2", 1'b1);
    tick();

    // 5: reset at row 2 of channel 1
    d0 = done_cnt;
    start_map(8'd4, 10'd2);
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (c == 1 && r == 2) break;
        await_row($sformatf("t5_c%0dr%0d", c, r),
                  (r == 0) ? K_FIRST : (r == 3) ? K_LAST : K_MID, 2, r, c, (c == 1), 1);
        finish_row($sformatf("t5_c%0dr%0d", c, r), 1'b0);
      end
    end
    await_row("t5_c1r2", K_MID, 2, 2, 1, 1'b1, 1);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_row", 32'(bus.row_idx), 32'd0);
    chk("t5_ch", 32'(bus.ch_idx), 32'd0);
    chk("t5_lastch", 32'(bus.last_channel), 32'd0);
    chk("t5_streams", 32'(kind_now()), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    run_map("t5_restart", 3, 1);

`ifdef CONV2D_ROW_SCHED_ABORT_EN
    // 6: abort wins over a same-cycle Done_1row
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_idle_abort", 32'(bus.aborted), 32'd0);
    d0 = done_cnt;
    start_map(8'd3, 10'd1);
    await_row("t6_r0", K_FIRST, 2, 0, 0, 1'b1, 1);
    repeat (2) tick();
    bus.abort = 1'b1;
    bus.Done_1row = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.Done_1row = 1'b0;
    chk("t6_aborted", 32'(bus.aborted), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_done", 32'(bus.done), 32'd0);
    s0 = stream_cnt;
    repeat (5) tick();
    chk("t6_aborted_off", 32'(bus.aborted), 32'd0);
    chk("t6_no_stream", 32'(stream_cnt - s0), 32'd0);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
